dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the RV64 pipeline's MEM-stage initiator (dm_addr/dm_din/dm_rd_ctrl/dm_wr_ctrl -> dm_dout).
//   Byte-addressed little-endian 64-bit-word RAM with LB..LD / SB..SD sizing and sign/zero extension.
//   Adds a configurable wait-state FSM and a dm_stall output that freezes the pipeline, so slow memory can be modelled.
// PARAMETERS
//   DEPTH    512  number of 64-bit words (power of 2); address wraps modulo DEPTH*8 bytes
//   LATENCY  2    stall cycles per access, 0..15; 0 = single-cycle, no stall
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   dm_addr      in   64  byte address
//   dm_din       in   64  store data, right-aligned (byte in [7:0], half in [15:0]...)
//   dm_rd_ctrl   in   3   0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWU,7 LD
//   dm_wr_ctrl   in   3   0 none,1 SB,2 SH,3 SW,4 SD,5-7 reserved (treated as none)
//   dm_dout      out  64  load data, extended to 64 bits
//   dm_stall     out  1   1 = hold MEM stage and all requests stable
//   dm_misalign  out  1   1-cycle pulse: access not naturally aligned
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, counter 0, dm_dout=0, dm_stall=0, dm_misalign=0; pending access dropped (no write). RAM contents are not reset.
//   Request = dm_rd_ctrl!=0 or dm_wr_ctrl in 1..4. Both set: write wins, dm_dout=0.
//   FSM IDLE -> BUSY -> RESP -> IDLE (LATENCY>0):
//     IDLE + request: latch addr/din/ctrl; dm_stall=1 combinationally this cycle; -> BUSY (LATENCY>1) or RESP (LATENCY==1).
//     BUSY: dm_stall=1; counter counts down; -> RESP after the LATENCY-th stall cycle. Input changes ignored.
//     RESP: dm_stall=0; dm_dout = read result; write commits at the rising edge ending RESP; -> IDLE.
//     Net: exactly LATENCY stall cycles per access, then one RESP cycle; back-to-back requests re-enter in the IDLE cycle after RESP.
//   LATENCY==0: no FSM; dm_stall tied 0; dm_dout combinational from RAM in request cycle; write commits at that cycle's edge.
//   dm_dout outside RESP (LATENCY>0) holds the last response value.
//   Word index = addr[$clog2(DEPTH)+2:3]; byte lane = addr[2:0]; upper address bits ignored (wrap).
//   Alignment: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0. Misaligned: no write, dm_dout=0, dm_misalign=1 in RESP (or request cycle if LATENCY==0).
//   Stores write only the selected byte lanes; other bytes of the word are unchanged.
//   Signed loads replicate bit 7/15/31 of the selected field into upper bits; U variants zero-fill.
//   Read-after-write to same address in consecutive accesses returns the new data (write committed before next request is latched).
// TESTING
//   LATENCY=2: SD addr 0x10 din 0x8877665544332211 -> dm_stall high 2 cycles, RESP cycle, word 2 = 0x8877665544332211.
//   Then LB 0x17 -> dout 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x88; LH 0x16 -> 0xFFFFFFFFFFFF8877; LWU 0x14 -> 0x88776655.
//   SB 0x11 din 0xAB then LD 0x10 -> 0x887766554433AB11 (other lanes preserved).
//   LW 0x12 -> dm_misalign pulse in RESP, dout 0; SH 0x13 -> no RAM change, misalign pulse.
//   Assert rst=0 in BUSY of SD 0x20 -> outputs 0 immediately, word 4 unchanged, next access starts from IDLE.
//   LATENCY=0: SW 0x8 din 0xDEADBEEF then LW 0x8 next cycle -> dm_stall never 1, dout 0xFFFFFFFFDEADBEEF same cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian 64-bit data memory with LB..LD / SB..SD sizing and sign/zero extension.
// Latency: LATENCY stall cycles then one response cycle; LATENCY==0 answers combinationally in the request cycle.
// Backpressure: dm_stall freezes the MEM stage while an access is in flight; requests must be held stable meanwhile.
module dmem_responder #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_din,
   input  logic [2:0]  dm_rd_ctrl,
   input  logic [2:0]  dm_wr_ctrl,
   output logic [63:0] dm_dout,
   output logic        dm_stall,
   output logic        dm_misalign
);

   localparam int AW = $clog2(DEPTH);
   // The request cycle counts as the first stall cycle, so BUSY covers the remaining LATENCY-1.
   localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [63:0] r_addr, r_din, r_dout;
   logic [2:0]  r_rd, r_wr;
   logic [63:0] r_mem [DEPTH];

   logic        w_req, w_stall, w_latch;
   logic [63:0] w_addr, w_din;
   logic [2:0]  w_rd, w_wr, w_rd_m1, w_wr_m1;
   logic        w_is_wr, w_is_rd, w_mis, w_we;
   logic [1:0]  w_sz;
   logic [AW-1:0] w_idx;
   logic [2:0]  w_lane;
   logic [63:0] w_word, w_field, w_result, w_wmask, w_wdata, w_new;
   logic [7:0]  w_bmask;
   logic        w_unused;

   assign w_req = (dm_rd_ctrl != 3'd0) || ((dm_wr_ctrl >= 3'd1) && (dm_wr_ctrl <= 3'd4));

   // With no wait states the live request is serviced directly; otherwise the latched copy is.
   assign w_addr = (LATENCY == 0) ? dm_addr    : r_addr;
   assign w_din  = (LATENCY == 0) ? dm_din     : r_din;
   assign w_rd   = (LATENCY == 0) ? dm_rd_ctrl : r_rd;
   assign w_wr   = (LATENCY == 0) ? dm_wr_ctrl : r_wr;

   assign w_is_wr = (w_wr >= 3'd1) && (w_wr <= 3'd4);
   assign w_is_rd = (w_rd != 3'd0) && !w_is_wr;   // write wins when both are requested
   assign w_rd_m1 = w_rd - 3'd1;
   assign w_wr_m1 = w_wr - 3'd1;
   assign w_sz    = w_is_wr ? w_wr_m1[1:0] : w_rd_m1[2:1];   // log2 of access size in bytes

   assign w_idx    = w_addr[AW+2:3];
   assign w_lane   = w_addr[2:0];
   assign w_unused = ^w_addr[63:AW+3];   // upper address bits wrap

   assign w_word  = r_mem[w_idx];
   assign w_field = w_word >> {w_lane, 3'b000};

   // Natural-alignment check for the selected access size.
   always_comb begin
      w_mis = 1'b0;
      if (w_is_wr || w_is_rd) begin
         case (w_sz)
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = w_lane[0];
            2'd2:    w_mis = |w_lane[1:0];
            default: w_mis = |w_lane;
         endcase
      end
   end

   // Load extraction with sign or zero extension; writes and misaligned loads return zero.
   always_comb begin
      w_result = 64'd0;
      if (w_is_rd && !w_mis) begin
         case (w_rd)
            3'd1:    w_result = {{56{w_field[7]}},  w_field[7:0]};
            3'd2:    w_result = {56'd0,             w_field[7:0]};
            3'd3:    w_result = {{48{w_field[15]}}, w_field[15:0]};
            3'd4:    w_result = {48'd0,             w_field[15:0]};
            3'd5:    w_result = {{32{w_field[31]}}, w_field[31:0]};
            3'd6:    w_result = {32'd0,             w_field[31:0]};
            default: w_result = w_field;
         endcase
      end
   end

   // Byte-lane merge so a narrow store leaves the rest of the word intact.
   always_comb begin
      case (w_sz)
         2'd0:    w_bmask = 8'h01;
         2'd1:    w_bmask = 8'h03;
         2'd2:    w_bmask = 8'h0F;
         default: w_bmask = 8'hFF;
      endcase
      w_bmask = w_bmask << w_lane;
      w_wmask = 64'd0;
      for (int i = 0; i < 8; i++) begin
         w_wmask[i*8 +: 8] = {8{w_bmask[i]}};
      end
      w_wdata = w_din << {w_lane, 3'b000};
      w_new   = (w_word & ~w_wmask) | (w_wdata & w_wmask);
   end

   assign w_we = rst && w_is_wr && !w_mis && ((LATENCY == 0) || (r_state == S_RESP));

   // Wait-state sequencing: request cycle and BUSY stall, RESP releases the pipeline.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && (LATENCY > 0)) begin
               w_stall     = 1'b1;
               w_latch     = 1'b1;
               w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, counter, request capture and held response; reset drops any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 64'd0;
         r_din   <= 64'd0;
         r_rd    <= 3'd0;
         r_wr    <= 3'd0;
         r_dout  <= 64'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_addr <= dm_addr;
            r_din  <= dm_din;
            r_rd   <= dm_rd_ctrl;
            r_wr   <= dm_wr_ctrl;
         end
         if (r_state == S_RESP) begin
            r_dout <= w_result;
         end
      end
   end

   // RAM storage is not reset; a store commits at the edge that ends its response cycle.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_idx] <= w_new;
      end
   end

   assign dm_stall    = rst && w_stall;
   assign dm_misalign = rst && w_mis && ((LATENCY == 0) || (r_state == S_RESP));
   assign dm_dout     = !rst ? 64'd0 :
                        ((LATENCY == 0) || (r_state == S_RESP)) ? w_result : r_dout;

endmodule
